// File: rtl/fft16_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft16_sequencer
// Purpose  : Buffers a 16-point complex frame, schedules the 4 radix-2 DIF
//            stages on an external butterfly PE, then streams the bins out.
// Revision : 1.0 - initial release
// ============================================================================
module fft16_sequencer #(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [31:0] pe_a_o,
  output logic [31:0] pe_b_o,
  output logic [2:0]  pe_power_o,
  output logic        pe_valid_o,
  input  logic [31:0] pe_fft_a_i,
  input  logic [31:0] pe_fft_b_i,
  input  logic        pe_fft_valid_i,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        frame_done_o,
  output logic        err_unexpected_o
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [OW-1:0] C_MAX_OUT = OW'(MAX_OUT);
  localparam logic [PW-1:0] C_PTR_LAST = PW'(MAX_OUT - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DRAIN, ST_OUT} state_t;

  state_t          state_q, state_d;
  logic [3:0]      icnt_q, icnt_d, ocnt_q, ocnt_d;
  logic [2:0]      j_q, j_d;
  logic [1:0]      s_q, s_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            in_ready_q, in_ready_d;
  logic            frame_done_q, frame_done_d;
  logic            err_q, err_d;

  logic [31:0]     buf_q [16];
  logic [7:0]      tag_q [MAX_OUT];

  logic [3:0]      top_addr, bot_addr, span, orev;
  logic [2:0]      power;
  logic [7:0]      rd_tag;
  logic            issue, ret, unexp, in_xfer;

  assign issue   = (state_q == ST_RUN) && (outst_q < C_MAX_OUT);
  assign ret     = pe_fft_valid_i && (outst_q != '0);
  assign unexp   = pe_fft_valid_i && (outst_q == '0);
  assign in_xfer = (state_q == ST_LOAD) && in_ready_q && in_valid_i;
  assign rd_tag  = tag_q[rd_ptr_q];
  assign orev    = {ocnt_q[0], ocnt_q[1], ocnt_q[2], ocnt_q[3]};

  // Top index inserts a zero at bit (3-s) of j; power keeps the low bits of j.
  always_comb begin
    top_addr = {1'b0, j_q};
    power    = j_q;
    case (s_q)
      2'd0: begin
        top_addr = {1'b0, j_q};
        power    = j_q;
      end
      2'd1: begin
        top_addr = {j_q[2], 1'b0, j_q[1:0]};
        power    = {j_q[1:0], 1'b0};
      end
      2'd2: begin
        top_addr = {j_q[2:1], 1'b0, j_q[0]};
        power    = {j_q[0], 2'b00};
      end
      default: begin
        top_addr = {j_q, 1'b0};
        power    = 3'd0;
      end
    endcase
    span     = 4'd8 >> s_q;
    bot_addr = top_addr | span;
  end

  always_comb begin
    state_d      = state_q;
    icnt_d       = icnt_q;
    ocnt_d       = ocnt_q;
    j_d          = j_q;
    s_d          = s_q;
    frame_done_d = 1'b0;
    err_d        = err_q | unexp;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    outst_d      = outst_q;

    case (state_q)
      ST_LOAD: begin
        if (in_xfer) begin
          icnt_d = icnt_q + 4'd1;
          if (icnt_q == 4'd15) begin
            state_d = ST_RUN;
            s_d     = 2'd0;
            j_d     = 3'd0;
          end
        end
      end
      ST_RUN: begin
        if (issue) begin
          j_d = j_q + 3'd1;
          if (j_q == 3'd7) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outst_q == '0) begin
          if (s_q != 2'd3) begin
            s_d     = s_q + 2'd1;
            j_d     = 3'd0;
            state_d = ST_RUN;
          end else begin
            ocnt_d  = 4'd0;
            state_d = ST_OUT;
          end
        end
      end
      default: begin
        if (out_ready_i) begin
          ocnt_d = ocnt_q + 4'd1;
          if (ocnt_q == 4'd15) begin
            state_d      = ST_LOAD;
            icnt_d       = 4'd0;
            frame_done_d = 1'b1;
          end
        end
      end
    endcase

    if (issue) wr_ptr_d = (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (ret)   rd_ptr_d = (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (issue && !ret)      outst_d = outst_q + 1'b1;
    else if (!issue && ret) outst_d = outst_q - 1'b1;

    // Hold in_ready low on the frame_done cycle so a new frame starts one cycle later.
    in_ready_d = (state_q == ST_LOAD) && (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      icnt_q       <= 4'd0;
      ocnt_q       <= 4'd0;
      j_q          <= 3'd0;
      s_q          <= 2'd0;
      outst_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      icnt_q       <= icnt_d;
      ocnt_q       <= ocnt_d;
      j_q          <= j_d;
      s_q          <= s_d;
      outst_q      <= outst_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      in_ready_q   <= in_ready_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer) buf_q[icnt_q] <= in_data_i;
    if (ret) begin
      buf_q[rd_tag[7:4]] <= pe_fft_a_i;
      buf_q[rd_tag[3:0]] <= pe_fft_b_i;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) tag_q[wr_ptr_q] <= {top_addr, bot_addr};
  end

  assign in_ready_o       = in_ready_q;
  assign pe_valid_o       = issue;
  assign pe_a_o           = issue ? buf_q[top_addr] : 32'd0;
  assign pe_b_o           = issue ? buf_q[bot_addr] : 32'd0;
  assign pe_power_o       = issue ? power : 3'd0;
  assign out_valid_o      = (state_q == ST_OUT);
  assign out_data_o       = (state_q == ST_OUT) ? buf_q[orev] : 32'd0;
  assign frame_done_o     = frame_done_q;
  assign err_unexpected_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft16_sequencer.sv
`default_nettype none
// Scoreboard bench for fft16_sequencer: random frames, a variable-latency PE model
// and a high-level DIF reference feeding expected-issue and expected-bin queues.
module tb_fft16_sequencer;
  localparam int MAX_OUT = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] in_data = '0, pe_a, pe_b, pe_fft_a = '0, pe_fft_b = '0, out_data;
  logic        in_valid = 1'b0, in_ready, pe_valid, pe_fft_valid, out_valid;
  logic        out_ready = 1'b0, frame_done, err;
  logic [2:0]  pe_power;
  logic        pe_v_model = 1'b0, inject_v = 1'b0;

  assign pe_fft_valid = pe_v_model | inject_v;

  fft16_sequencer #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .pe_a_o(pe_a), .pe_b_o(pe_b), .pe_power_o(pe_power), .pe_valid_o(pe_valid),
    .pe_fft_a_i(pe_fft_a), .pe_fft_b_i(pe_fft_b), .pe_fft_valid_i(pe_fft_valid),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .frame_done_o(frame_done), .err_unexpected_o(err)
  );

  initial forever #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  checks = 0, failures = 0;
  int  lat = 1, rdy_mode = 0, mon_issues = 0;
  bit  stall_en = 1'b0, time_check = 1'b0, exp_err = 1'b0;
  logic [66:0] exp_issue [$];
  logic [31:0] exp_out [$];
  logic [31:0] ref_buf [16];

  typedef struct { longint due; logic [63:0] res; } pe_item_t;
  pe_item_t pend [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic longint tw_re(input int k);
    case (k)
      0: return 65536;  1: return 60547;  2: return 46341;  3: return 25080;
      4: return 0;      5: return -25080; 6: return -46341; default: return -60547;
    endcase
  endfunction

  function automatic longint tw_im(input int k);
    case (k)
      0: return 0;       1: return -25080; 2: return -46341; 3: return -60547;
      4: return -65536;  5: return -60547; 6: return -46341; default: return -25080;
    endcase
  endfunction

  // Behavioural butterfly: unscaled sum, (a-b)*W16^k with Q16 twiddles, product >>16.
  function automatic logic [63:0] bfly(input logic [31:0] a, input logic [31:0] b, input int k);
    longint ar, ai, br, bi, dr, di, pr, pim;
    ar  = longint'($signed(a[31:16])); ai = longint'($signed(a[15:0]));
    br  = longint'($signed(b[31:16])); bi = longint'($signed(b[15:0]));
    dr  = ar - br;
    di  = ai - bi;
    pr  = (dr * tw_re(k) - di * tw_im(k)) >>> 16;
    pim = (dr * tw_im(k) + di * tw_re(k)) >>> 16;
    return {16'(ar + br), 16'(ai + bi), 16'(pr), 16'(pim)};
  endfunction

  function automatic int bitrev4(input int v);
    return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
  endfunction

  task automatic build_expect();
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < 8; j++) begin
        int span, top, bot, k;
        logic [63:0] r;
        span = 8 >> s;
        top  = (j / span) * 2 * span + (j % span);
        bot  = top + span;
        k    = (j % span) << s;
        exp_issue.push_back({ref_buf[top], ref_buf[bot], 3'(k)});
        r = bfly(ref_buf[top], ref_buf[bot], k);
        ref_buf[top] = r[63:32];
        ref_buf[bot] = r[31:0];
      end
    end
    for (int o = 0; o < 16; o++) exp_out.push_back(ref_buf[bitrev4(o)]);
  endtask

  // PE model: in-order results after 'lat' cycles, optional random extra stalls.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pend.delete();
      pe_v_model = 1'b0;
    end else begin
      int n_before;
      n_before   = pend.size();
      pe_v_model = 1'b0;
      if (n_before > 0 && pend[0].due <= cyc && !(stall_en && $urandom_range(0, 3) == 0)) begin
        {pe_fft_a, pe_fft_b} = pend[0].res;
        pend.pop_front();
        pe_v_model = 1'b1;
      end
      if (pe_valid) begin
        chk("pe_issue_with_max_outstanding", 64'(n_before < MAX_OUT), 64'd1);
        pend.push_back('{due: cyc + lat, res: bfly(pe_a, pe_b, int'(pe_power))});
      end
    end
  end

  // Monitor: pops the scoreboard queues whenever the DUT presents something.
  initial begin
    logic [31:0] held;
    logic [66:0] e;
    bit hold_prev, busy, exp_fd, ready_after, seen_out;
    int icount, ocount;
    longint first_run;
    held = '0; hold_prev = 0; busy = 0; exp_fd = 0; ready_after = 0; seen_out = 0;
    icount = 0; ocount = 0; first_run = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 0; hold_prev = 0; exp_fd = 0; ready_after = 0; seen_out = 0;
        icount = 0; ocount = 0; mon_issues = 0; first_run = -1; exp_err = 0;
      end else begin
        if (frame_done || exp_fd) chk("frame_done", 64'(frame_done), 64'(exp_fd));
        exp_fd = 0;
        if (ready_after) chk("in_ready_after_done", 64'(in_ready), 64'd1);
        ready_after = frame_done;
        if (busy) chk("in_ready_while_busy", 64'(in_ready), 64'd0);
        if (frame_done) busy = 0;
        if (in_valid && in_ready) begin
          icount++;
          if (icount == 16) begin
            icount = 0; busy = 1; mon_issues = 0; first_run = -1; seen_out = 0;
          end
        end
        if (pe_valid) begin
          if (first_run < 0) first_run = cyc;
          if (exp_issue.size() == 0) begin
            chk("pe_issue_unexpected", 64'(pe_power), 64'hdead);
          end else begin
            e = exp_issue.pop_front();
            chk("pe_a", 64'(pe_a), 64'(e[66:35]));
            chk("pe_b", 64'(pe_b), 64'(e[34:3]));
            chk("pe_power", 64'(pe_power), 64'(e[2:0]));
          end
          mon_issues++;
        end
        if (hold_prev) begin
          chk("out_valid_hold", 64'(out_valid), 64'd1);
          chk("out_data_hold", 64'(out_data), 64'(held));
        end
        hold_prev = 0;
        if (out_valid) begin
          if (!seen_out) begin
            seen_out = 1;
            if (time_check) chk("run_to_out_cycles", 64'(cyc - first_run), 64'd40);
          end
          if (out_ready) begin
            if (exp_out.size() == 0) chk("out_unexpected", 64'(out_data), 64'hdead);
            else chk("out_bin", 64'(out_data), 64'(exp_out.pop_front()));
            ocount++;
            if (ocount == 16) begin
              ocount = 0;
              exp_fd = 1;
            end
          end else begin
            hold_prev = 1;
            held      = out_data;
          end
        end
        chk("err_unexpected", 64'(err), 64'(exp_err));
        if (inject_v) exp_err = 1;
      end
    end
  end

  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (k % 4 == 0) || (k % 4 == 3);
          if (out_valid) k++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_pe_valid", 64'(pe_valid), 64'd0);
    chk("rst_pe_operands", {pe_a, pe_b}, 64'd0);
    chk("rst_pe_power", 64'(pe_power), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_err_unexpected", 64'(err), 64'd0);
  endtask

  task automatic release_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_before_first_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready_first_cycle", 64'(in_ready), 64'd1);
  endtask

  task automatic run_frame(input bit rnd, input int f_lat, input bit f_stall, input int f_rdy,
                           input bit hold_valid, input bit mid_reset, input bit do_inject);
    logic [31:0] x [16];
    int i, guard;
    lat        = f_lat;
    stall_en   = f_stall;
    rdy_mode   = f_rdy;
    time_check = (f_lat == 1) && !f_stall && !mid_reset;
    for (int n = 0; n < 16; n++) x[n] = rnd ? $urandom : 32'h0010_0000;
    ref_buf = x;
    build_expect();
    if (do_inject) begin
      @(posedge clk); #1 inject_v = 1'b1;
      @(posedge clk); #1 inject_v = 1'b0;
    end
    i = 0;
    guard = 0;
    while (i < 16) begin
      @(posedge clk); #1;
      in_valid = (!rnd || hold_valid) ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data  = x[i];
      @(negedge clk);
      if (in_valid && in_ready) i++;
      if (++guard > 500) timeout("load_frame");
    end
    @(posedge clk); #1;
    in_valid = hold_valid;
    in_data  = $urandom;
    if (mid_reset) begin
      guard = 0;
      while (mon_issues < 10) begin
        @(posedge clk);
        if (++guard > 200) timeout("reach_stage1");
      end
      #2 rst = 1'b1;
      #1 chk_reset_outputs();
      exp_issue.delete();
      exp_out.delete();
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      release_reset();
    end else begin
      guard = 0;
      do begin
        @(negedge clk);
        if (++guard > 3000) timeout("frame_done_wait");
      end while (!frame_done);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    release_reset();
    run_frame(1'b0, 1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    run_frame(1'b1, 3, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    run_frame(1'b1, 6, 1'b1, 2, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 4; f++)
      run_frame(1'b1, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 2,
                1'($urandom_range(0, 1)), 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("bins_left_unchecked", 64'(exp_out.size()), 64'd0);
    chk("issues_left_unchecked", 64'(exp_issue.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
